// File: rtl/l1_mem_responder_pkg.sv
// Shared types for the L1D <-> memory line bus: line and id types plus the
// response payload carried through the responder's output queue.
package l1_mem_responder_pkg;

  localparam int MEM_LINE_W = 128;
  localparam int MEM_ID_W   = 2;
  localparam int MEM_OFF_W  = $clog2(MEM_LINE_W / 8);

  typedef logic [MEM_LINE_W-1:0] line_t;
  typedef logic [MEM_ID_W-1:0]   bus_id_t;

  typedef struct packed {
    bus_id_t id;
    line_t   data;
  } mem_resp_t;

endpackage

// File: rtl/l1_mem_responder_resp_fifo.sv
// Circular DEPTH-entry FIFO of mem_resp_t; push and pop may coincide when
// full or empty, and a push into an empty FIFO is visible the next cycle.
module resp_fifo
  import l1_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  mem_resp_t wdata,
  input  logic      pop,
  output mem_resp_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  mem_resp_t        store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = store_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, the slot being popped is the slot being written.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/l1_mem_responder.sv
// Line-granular memory responder: array access at acceptance, fixed-latency
// delay pipeline, in-order response queue, credit-based request backpressure.
module l1_mem_responder
  import l1_mem_responder_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = MEM_LINE_W,
  parameter int ID_W      = MEM_ID_W,
  parameter int MEM_LINES = 1024,
  parameter int LATENCY   = 4,
  parameter int DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_data,
  input  logic [ID_W-1:0]   req_id,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_data,
  output logic [ID_W-1:0]   resp_id
);

  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [LINE_W-1:0] mem_q [MEM_LINES];
  logic [IDX_W-1:0]  req_idx;
  logic              accept, retire;

  logic              pipe_vld_q  [LATENCY];
  logic              pipe_vld_d  [LATENCY];
  logic              pipe_we_q   [LATENCY];
  logic              pipe_we_d   [LATENCY];
  logic [ID_W-1:0]   pipe_id_q   [LATENCY];
  logic [ID_W-1:0]   pipe_id_d   [LATENCY];
  logic [LINE_W-1:0] pipe_data_q [LATENCY];
  logic [LINE_W-1:0] pipe_data_d [LATENCY];

  logic [CNT_W-1:0]  out_q, out_d;
  mem_resp_t         fifo_wdata, fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              unused_ok;

  assign req_idx    = req_addr[OFF +: IDX_W];
  assign req_ready  = (out_q < CNT_W'(DEPTH));
  assign accept     = req_valid && req_ready;
  assign resp_valid = !fifo_empty;
  assign retire     = resp_valid && resp_ready;
  assign unused_ok  = ^{fifo_full, req_addr[ADDR_W-1:OFF+IDX_W], req_addr[OFF-1:0]};

  // Stage 0 latches the pre-write array contents, giving read-old semantics.
  assign pipe_vld_d[0]  = accept;
  assign pipe_we_d[0]   = req_we;
  assign pipe_id_d[0]   = req_id;
  assign pipe_data_d[0] = mem_q[req_idx];

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
    assign pipe_vld_d[gi]  = pipe_vld_q[gi-1];
    assign pipe_we_d[gi]   = pipe_we_q[gi-1];
    assign pipe_id_d[gi]   = pipe_id_q[gi-1];
    assign pipe_data_d[gi] = pipe_data_q[gi-1];
  end

  always_comb begin
    out_d = out_q;
    if (accept && !retire)      out_d = out_q + CNT_W'(1);
    else if (!accept && retire) out_d = out_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) pipe_vld_q[i] <= 1'b0;
      out_q <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) pipe_vld_q[i] <= pipe_vld_d[i];
      out_q <= out_d;
    end
  end

  // Payload flops and the line array are deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      pipe_we_q[i]   <= pipe_we_d[i];
      pipe_id_q[i]   <= pipe_id_d[i];
      pipe_data_q[i] <= pipe_data_d[i];
    end
    if (accept && req_we) mem_q[req_idx] <= req_data;
  end

  assign fifo_wdata.id   = pipe_id_q[LATENCY-1];
  assign fifo_wdata.data = pipe_we_q[LATENCY-1] ? '0 : pipe_data_q[LATENCY-1];

  resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (pipe_vld_q[LATENCY-1]),
    .wdata (fifo_wdata),
    .pop   (resp_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign resp_data = fifo_empty ? '0 : fifo_rdata.data;
  assign resp_id   = fifo_empty ? '0 : fifo_rdata.id;

endmodule

// File: tb/tb_l1_mem_responder.sv
// Scenario bench for l1_mem_responder: a negedge monitor models the line
// array, queues expected responses on acceptance and checks them on retire.
`timescale 1ns/1ps
module tb_l1_mem_responder;

  localparam int LATENCY = 4;
  localparam int DEPTH   = 4;
  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hFEDCBA9876543210_55AA55AA_33CC33CC;
  localparam logic [127:0] D3 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic [1:0]   req_id = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [127:0] resp_data;
  logic [1:0]   resp_id;

  always #5 clk = ~clk;

  l1_mem_responder #(
    .ADDR_W(32), .LINE_W(128), .ID_W(2), .MEM_LINES(1024), .LATENCY(LATENCY), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .req_id(req_id),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id)
  );

  typedef struct {
    logic [1:0]   id;
    logic [127:0] data;
  } exp_t;

  int           total_cnt = 0;
  int           pass_cnt  = 0;
  int           cyc       = 0;
  int           resp_cnt  = 0;
  exp_t         sb [$];
  int           ret_cyc [$];
  logic [127:0] model [int];
  exp_t         mon_e;
  logic         stall_prev = 1'b0;
  logic [1:0]   stall_id;
  logic [127:0] stall_data;

  function automatic int line_idx(input logic [31:0] a);
    return int'((a >> 4) & 32'h3FF);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: handshakes sampled mid-cycle, where they equal what the next edge sees.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        total_cnt++;
        if (resp_valid !== 1'b1 || resp_id !== stall_id || resp_data !== stall_data)
          $display("FAIL stall_stable: got valid=%b id=%0d data=%h, expected valid=1 id=%0d data=%h",
                   resp_valid, resp_id, resp_data, stall_id, stall_data);
        else pass_cnt++;
      end
      if (dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop) begin
        total_cnt++;
        $display("FAIL queue_overflow: push into full queue without pop at cycle %0d", cyc);
      end
      if (req_valid && req_ready) begin
        mon_e.id = req_id;
        if (req_we) begin
          model[line_idx(req_addr)] = req_data;
          mon_e.data = '0;
        end else begin
          mon_e.data = model.exists(line_idx(req_addr)) ? model[line_idx(req_addr)] : 'x;
        end
        sb.push_back(mon_e);
      end
      if (resp_valid && resp_ready) begin
        total_cnt++;
        resp_cnt++;
        ret_cyc.push_back(cyc);
        $display("resp cyc=%0d id=%0d data=%h", cyc, resp_id, resp_data);
        if (sb.size() == 0) begin
          $display("FAIL resp_unexpected: got id=%0d data=%h, expected no response", resp_id, resp_data);
        end else begin
          mon_e = sb.pop_front();
          if (resp_id !== mon_e.id || resp_data !== mon_e.data)
            $display("FAIL resp_match: got id=%0d data=%h, expected id=%0d data=%h",
                     resp_id, resp_data, mon_e.id, mon_e.data);
          else pass_cnt++;
        end
      end
      stall_prev = resp_valid && !resp_ready;
      stall_id   = resp_id;
      stall_data = resp_data;
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [127:0] data,
                      input logic [1:0] id, output int t_acc);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data; req_id = id;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    t_acc = cyc;
    if (!req_ready) begin
      total_cnt++;
      $display("FAIL send_timeout: got req_ready=0 for 100 cycles, expected 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (sb.size() == 0);
    @(posedge clk); #1;
  endtask

  task automatic set_thr_fields(input int k);
    req_we   = (k % 2 == 0);
    req_addr = (k % 2 == 0) ? 32'h300 + 32'(16 * k) : 32'h100 + 32'(16 * (k % 4));
    req_data = {4{32'(k) ^ 32'hA5A5_0000}};
    req_id   = 2'(k);
  endtask

  task automatic test_reset();
    int  base;
    bit  seen;
    #1 rst = 1'b0;
    #11;
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL rst_hold_valid: got %b, expected 0", resp_valid);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL rst_hold_ready: got %b, expected 1", req_ready);
    else pass_cnt++;
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b, expected 1", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b, expected 0", resp_valid);
    else pass_cnt++;
    total_cnt++;
    if (resp_id !== 2'd0) $display("FAIL rst_resp_id: got %0d, expected 0", resp_id);
    else pass_cnt++;
    total_cnt++;
    if (resp_data !== '0) $display("FAIL rst_resp_data: got %h, expected 0", resp_data);
    else pass_cnt++;
    base = resp_cnt;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen || resp_cnt != base) $display("FAIL idle_quiet: got resp_valid seen=%b, expected never", seen);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int a1, a2, b;
    bit ok;
    resp_ready = 1'b1;
    b = ret_cyc.size();
    send(1'b1, 32'h40, D1, 2'd1, a1);
    send(1'b0, 32'h4C, '0, 2'd2, a2);
    wait_drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL wr_rd_drain: got %0d pending, expected 0", sb.size());
    else pass_cnt++;
    total_cnt++;
    if (ret_cyc.size() != b + 2) begin
      $display("FAIL wr_rd_count: got %0d responses, expected 2", ret_cyc.size() - b);
    end else begin
      pass_cnt++;
      total_cnt++;
      if (ret_cyc[b] - a1 != LATENCY + 1)
        $display("FAIL wr_ack_latency: got %0d, expected %0d", ret_cyc[b] - a1, LATENCY + 1);
      else pass_cnt++;
      total_cnt++;
      if (ret_cyc[b+1] - a1 != LATENCY + 2)
        $display("FAIL rd_latency: got %0d, expected %0d", ret_cyc[b+1] - a1, LATENCY + 2);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    int t;
    bit ok;
    resp_ready = 1'b1;
    send(1'b1, 32'h40, D2, 2'd0, t);
    send(1'b0, 32'h4040, '0, 2'd3, t);
    wait_drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL wrap_drain: got %0d pending, expected 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int t, n_acc, k;
    bit ok;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(1'b1, 32'h100 + 32'(16 * i), {4{32'h1000_0000 + 32'(i)}}, 2'(i), t);
    wait_drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL bp_seed_drain: got %0d pending, expected 0", sb.size());
    else pass_cnt++;

    resp_ready = 1'b0;
    n_acc = 0;
    k = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_id = 2'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (n_acc == 4) begin
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL credit_block: got req_ready=%b, expected 0", req_ready);
        else pass_cnt++;
      end
      if (req_ready) begin
        n_acc++;
        k++;
      end
      @(posedge clk); #1;
      req_addr = 32'h100 + 32'(16 * k);
      req_id   = 2'(k);
    end
    req_valid = 1'b0;
    total_cnt++;
    if (n_acc != 4) $display("FAIL credit_accepts: got %0d, expected 4", n_acc);
    else pass_cnt++;

    resp_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL first_retire: got valid=%b ready=%b, expected valid=1 ready=0", resp_valid, req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL credit_return: got req_ready=%b, expected 1", req_ready);
    else pass_cnt++;
    wait_drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL bp_drain: got %0d pending, expected 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int k, n, b, base, first_acc;
    bit ok;
    resp_ready = 1'b1;
    b = ret_cyc.size();
    base = resp_cnt;
    k = 0;
    n = 0;
    first_acc = 0;
    req_valid = 1'b1;
    set_thr_fields(0);
    while (k < 12 && n < 200) begin
      @(negedge clk);
      if (req_ready) begin
        if (k == 0) first_acc = cyc;
        k++;
      end
      @(posedge clk); #1;
      set_thr_fields(k);
      n++;
    end
    req_valid = 1'b0;
    total_cnt++;
    if (k != 12) $display("FAIL thr_issue: got %0d accepted, expected 12", k);
    else pass_cnt++;
    wait_drain(ok);
    total_cnt++;
    if (!ok || resp_cnt - base != 12)
      $display("FAIL thr_count: got %0d responses, expected 12", resp_cnt - base);
    else pass_cnt++;
    if (ret_cyc.size() >= b + 4) begin
      total_cnt++;
      if (ret_cyc[b] - first_acc != LATENCY + 1)
        $display("FAIL thr_latency: got %0d, expected %0d", ret_cyc[b] - first_acc, LATENCY + 1);
      else pass_cnt++;
      total_cnt++;
      if (ret_cyc[b+3] - ret_cyc[b] != 3)
        $display("FAIL thr_burst: got span %0d, expected 3", ret_cyc[b+3] - ret_cyc[b]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int t, n, base;
    bit ok, seen;
    resp_ready = 1'b0;
    send(1'b1, 32'h80, D3, 2'd1, t);
    send(1'b0, 32'h100, '0, 2'd2, t);
    send(1'b1, 32'h90, D2, 2'd3, t);
    n = 0;
    @(negedge clk);
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (resp_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b, expected 1", resp_valid);
    else pass_cnt++;
    base = resp_cnt;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL rst_async_valid: got %b, expected 0", resp_valid);
    else pass_cnt++;
    @(negedge clk); #2 rst = 1'b1;
    resp_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen || resp_cnt != base) $display("FAIL mid_dropped: got %0d responses, expected 0", resp_cnt - base);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL mid_req_ready: got %b, expected 1", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    send(1'b0, 32'h80, '0, 2'd0, t);
    wait_drain(ok);
    total_cnt++;
    if (!ok || resp_cnt != base + 1)
      $display("FAIL mid_readback: got %0d responses, expected 1", resp_cnt - base);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
